// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Bus layouts here must match the ID-stage decode of if_to_id_bus / br_bus.
package if_fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam int          IF_TO_ID_WD      = 33;
  localparam int          BR_WD            = 33;
  localparam int          STALL_WD         = 6;

  localparam int   STALL_IF = 0;
  localparam int   STALL_ID = 1;
  localparam logic STOP     = 1'b1;
  localparam logic NO_STOP  = 1'b0;

  typedef struct packed {
    logic        br_e;
    logic [31:0] br_addr;
  } br_bus_t;

  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
  } if_to_id_t;

  // Sequential fetch; wraps silently at 2^32.
  function automatic logic [31:0] pc_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_stage_hold_buf.sv
// Instruction hold buffer: freezes the word seen on the first ID-stall cycle
// so ID keeps a stable instruction paired with its PC until the stall drops.
module fetch_hold_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         hold_req,
  input  logic [W-1:0] rdata_in,
  output logic [W-1:0] inst_out,
  output logic         hold_v
);

  logic         hold_v_q,    hold_v_d;
  logic [W-1:0] hold_inst_q, hold_inst_d;

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_inst_d = hold_inst_q;
    if (!hold_req) begin
      hold_v_d = 1'b0;
    end else if (!hold_v_q) begin
      // Capture only once per stall run; later SRAM data belongs to newer PCs.
      hold_v_d    = 1'b1;
      hold_inst_d = rdata_in;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_v_q    <= 1'b0;
      hold_inst_q <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  assign inst_out = hold_v_q ? hold_inst_q : rdata_in;
  assign hold_v   = hold_v_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, redirect held across
// IF stalls, instruction SRAM request and the ID-facing instruction hold buffer.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [STALL_WD-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata,
  output logic [31:0]            id_inst,
  output logic                   id_inst_valid
);

  br_bus_t   br;
  if_to_id_t to_id;

  logic [31:0] pc_q,        pc_d;
  logic        ce_q,        ce_d;
  logic        pend_v_q,    pend_v_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] next_pc;
  logic        if_stop;

  // Only the IF and ID stall bits matter here; the rest belong to later stages.
  logic unused_stall;
  assign unused_stall = ^stall[STALL_WD-1:2];

  assign br      = br_bus;
  assign if_stop = (stall[STALL_IF] == STOP);

  always_comb begin
    if (br.br_e)       next_pc = br.br_addr;
    else if (pend_v_q) next_pc = pend_addr_q;
    else               next_pc = pc_seq(pc_q);
  end

  always_comb begin
    pc_d        = pc_q;
    ce_d        = ce_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    if (!if_stop) begin
      pc_d     = next_pc;
      ce_d     = 1'b1;
      pend_v_d = 1'b0;
    end else if (br.br_e) begin
      // br_e is a one-cycle pulse from ID; park it until IF can move.
      pend_v_d    = 1'b1;
      pend_addr_d = br.br_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q        <= RESET_PC - 32'd4;
      ce_q        <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      pc_q        <= pc_d;
      ce_q        <= ce_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign to_id.ce     = ce_q;
  assign to_id.pc     = pc_q;
  assign if_to_id_bus = to_id;

  assign inst_sram_en    = ce_q;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = pc_q;
  assign inst_sram_wdata = 32'b0;

  fetch_hold_buf #(.W(32)) u_hold (
    .clk      (clk),
    .resetn   (resetn),
    .hold_req (stall[STALL_ID] == STOP),
    .rdata_in (inst_sram_rdata),
    .inst_out (id_inst),
    .hold_v   (id_inst_valid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: fixed vector table, hand sequences for stall/redirect
// corners and async reset, then random traffic against a behavioural model.
module tb_if_fetch_stage;

  logic        clk;
  logic        resetn;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] id_inst;
  logic        id_inst_valid;

  int n_vec = 0;
  int n_err = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .resetn          (resetn),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .id_inst         (id_inst),
    .id_inst_valid   (id_inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fetch address, pending-redirect queue, ID stall run length.
  logic [31:0] m_pc;
  logic        m_ce;
  logic [31:0] m_pend[$];
  int          m_run;
  logic [31:0] m_word;

  task automatic model_reset();
    m_pc   = 32'hBFC0_0000 - 32'd4;
    m_ce   = 1'b0;
    m_pend.delete();
    m_run  = 0;
    m_word = 32'h0;
  endtask

  task automatic model_edge(input logic [5:0] st, input logic be,
                            input logic [31:0] ba, input logic [31:0] rd);
    if (!st[0]) begin
      if (be)                  m_pc = ba;
      else if (m_pend.size())  m_pc = m_pend[0];
      else                     m_pc = m_pc + 32'd4;
      m_pend.delete();
      m_ce = 1'b1;
    end else if (be) begin
      m_pend.delete();
      m_pend.push_back(ba);
    end
    if (st[1]) begin
      if (m_run == 0) m_word = rd;
      m_run++;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input logic [31:0] rd);
    cmp("m_addr",  64'(inst_sram_addr), 64'(m_pc));
    cmp("m_en",    64'(inst_sram_en),   64'(m_ce));
    cmp("m_bus",   64'(if_to_id_bus),   64'({m_ce, m_pc}));
    cmp("m_inst",  64'(id_inst),        64'((m_run > 0) ? m_word : rd));
    cmp("m_valid", 64'(id_inst_valid),  64'(m_run > 0));
    cmp("m_wen",   64'(inst_sram_wen),  64'(0));
    cmp("m_wdata", 64'(inst_sram_wdata), 64'(0));
  endtask

  task automatic step(input logic [5:0] st, input logic be, input logic [31:0] ba,
                      input logic [31:0] rd, input logic chk,
                      input logic [31:0] e_addr, input logic e_ce,
                      input logic [31:0] e_inst, input logic e_hv, input string nm);
    stall           = st;
    br_bus          = {be, ba};
    inst_sram_rdata = rd;
    #1;
    check_model(rd);
    if (chk) begin
      cmp({nm, "_addr"},  64'(inst_sram_addr), 64'(e_addr));
      cmp({nm, "_ce"},    64'(if_to_id_bus[32]), 64'(e_ce));
      cmp({nm, "_inst"},  64'(id_inst), 64'(e_inst));
      cmp({nm, "_valid"}, 64'(id_inst_valid), 64'(e_hv));
    end
    @(posedge clk);
    model_edge(st, be, ba, rd);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic async_reset(input string nm);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    cmp({nm, "_addr"},  64'(inst_sram_addr), 64'(32'hBFBF_FFFC));
    cmp({nm, "_en"},    64'(inst_sram_en), 64'(0));
    cmp({nm, "_valid"}, 64'(id_inst_valid), 64'(0));
    cmp({nm, "_inst"},  64'(id_inst), 64'(inst_sram_rdata));
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  typedef struct {
    logic [5:0]  st;
    logic        be;
    logic [31:0] ba;
    logic [31:0] rd;
    logic [31:0] e_addr;
    logic        e_ce;
    logic [31:0] e_inst;
    logic        e_hv;
  } vec_t;

  vec_t tbl[9];

  initial begin
    resetn          = 1'b0;
    stall           = 6'd0;
    br_bus          = 33'd0;
    inst_sram_rdata = 32'hDEAD_BEEF;
    model_reset();
    #12;
    cmp("rst_addr",  64'(inst_sram_addr), 64'(32'hBFBF_FFFC));
    cmp("rst_bus",   64'(if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
    cmp("rst_en",    64'(inst_sram_en), 64'(0));
    cmp("rst_inst",  64'(id_inst), 64'(32'hDEAD_BEEF));
    cmp("rst_valid", 64'(id_inst_valid), 64'(0));
    @(posedge clk);
    #1 resetn = 1'b1;

    // Sequential fetch, redirect, then ID stall with hold buffer.
    tbl[0] = '{6'd0, 1'b0, 32'h0,         32'hA0A0_A0A0, 32'hBFBF_FFFC, 1'b0, 32'hA0A0_A0A0, 1'b0};
    tbl[1] = '{6'd0, 1'b0, 32'h0,         32'hA1A1_A1A1, 32'hBFC0_0000, 1'b1, 32'hA1A1_A1A1, 1'b0};
    tbl[2] = '{6'd0, 1'b1, 32'hBFC0_0100, 32'hA2A2_A2A2, 32'hBFC0_0004, 1'b1, 32'hA2A2_A2A2, 1'b0};
    tbl[3] = '{6'd0, 1'b0, 32'h0,         32'hA3A3_A3A3, 32'hBFC0_0100, 1'b1, 32'hA3A3_A3A3, 1'b0};
    tbl[4] = '{6'd2, 1'b0, 32'h0,         32'h1111_1111, 32'hBFC0_0104, 1'b1, 32'h1111_1111, 1'b0};
    tbl[5] = '{6'd2, 1'b0, 32'h0,         32'h2222_2222, 32'hBFC0_0108, 1'b1, 32'h1111_1111, 1'b1};
    tbl[6] = '{6'd2, 1'b0, 32'h0,         32'h3333_3333, 32'hBFC0_010C, 1'b1, 32'h1111_1111, 1'b1};
    tbl[7] = '{6'd0, 1'b0, 32'h0,         32'h4444_4444, 32'hBFC0_0110, 1'b1, 32'h1111_1111, 1'b1};
    tbl[8] = '{6'd0, 1'b0, 32'h0,         32'h5555_5555, 32'hBFC0_0114, 1'b1, 32'h5555_5555, 1'b0};
    for (int i = 0; i < 9; i++)
      step(tbl[i].st, tbl[i].be, tbl[i].ba, tbl[i].rd, 1'b1,
           tbl[i].e_addr, tbl[i].e_ce, tbl[i].e_inst, tbl[i].e_hv, $sformatf("tbl%0d", i));

    // IF stall for three cycles with a redirect in the middle one.
    step(6'd1, 1'b0, 32'h0,         32'h0, 1'b1, 32'hBFC0_0118, 1'b1, 32'h0, 1'b0, "st1");
    step(6'd1, 1'b1, 32'hBFC0_0200, 32'h0, 1'b1, 32'hBFC0_0118, 1'b1, 32'h0, 1'b0, "st2");
    step(6'd1, 1'b0, 32'h0,         32'h0, 1'b1, 32'hBFC0_0118, 1'b1, 32'h0, 1'b0, "st3");
    step(6'd0, 1'b0, 32'h0,         32'h0, 1'b1, 32'hBFC0_0118, 1'b1, 32'h0, 1'b0, "st_rel");
    step(6'd0, 1'b0, 32'h0,         32'h0, 1'b1, 32'hBFC0_0200, 1'b1, 32'h0, 1'b0, "st_tgt");

    // Pending target A loses to a fresh redirect B on the release cycle.
    step(6'd1, 1'b1, 32'hBFC0_0300, 32'h0, 1'b1, 32'hBFC0_0204, 1'b1, 32'h0, 1'b0, "pendA");
    step(6'd0, 1'b1, 32'hBFC0_0400, 32'h0, 1'b1, 32'hBFC0_0204, 1'b1, 32'h0, 1'b0, "relB");
    step(6'd0, 1'b0, 32'h0,         32'h0, 1'b1, 32'hBFC0_0400, 1'b1, 32'h0, 1'b0, "tgtB");
    step(6'd0, 1'b0, 32'h0,         32'h0, 1'b1, 32'hBFC0_0404, 1'b1, 32'h0, 1'b0, "seqB");

    // Reset while IF and ID are stalled with a redirect pending.
    step(6'd3, 1'b1, 32'hBFC0_0500, 32'h7777_7777, 1'b1, 32'hBFC0_0408, 1'b1, 32'h7777_7777, 1'b0, "pre_rst");
    stall  = 6'd3;
    br_bus = 33'd0;
    async_reset("mid_rst");
    step(6'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBFBF_FFFC, 1'b0, 32'h0, 1'b0, "rs0");
    step(6'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0000, 1'b1, 32'h0, 1'b0, "rs1");
    step(6'd0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hBFC0_0004, 1'b1, 32'h0, 1'b0, "rs2");

    // Random traffic, including misaligned targets and address wrap.
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  st;
      logic        be;
      logic [31:0] ba;
      st = 6'($urandom);
      st[0] = ($urandom_range(0, 99) < 35);
      st[1] = ($urandom_range(0, 99) < 35);
      be = ($urandom_range(0, 99) < 20);
      ba = (i % 50 == 7) ? 32'hFFFF_FFF8 : $urandom;
      if ($urandom_range(0, 199) == 0) begin
        stall = st;
        async_reset("rnd_rst");
      end
      step(st, be, ba, $urandom, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
